multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the multi-cycle RV32I datapath: IF -> ID -> EX -> [MEM] -> [WB].
//  Drives IR/PC/regfile write enables, operand/PC-source selects and the I/D memory req/ack handshakes.
//  Per opcode, it selects which of the existing ALU control decoder's results are committed.
//  Counts retired instructions and flags halts, illegal opcodes and memory timeouts.
// PARAMETERS
//  CNT_W    32  width of retired-instruction counter
//  TIMEOUT  16  max cycles a req may wait for ack before err; 0 disables timeout
// PORTS
//  CLK         in   1      clock, rising edge
//  RSTn        in   1      asynchronous active-low reset
//  opcode      in   7      IR[6:0], from the instruction register (valid from ID onward)
//  br_taken    in   1      ALU compare result for the current branch (sampled in EX)
//  halt_req    in   1      datapath halt-pattern detect (sampled in ID)
//  i_req       out  1      instruction fetch request
//  i_ack       in   1      instruction word valid this cycle
//  d_req       out  1      data memory request
//  d_we        out  1      1 = store, 0 = load; valid only while d_req=1
//  d_ack       in   1      data access complete this cycle
//  ir_write    out  1      latch fetched word into IR
//  pc_write    out  1      update PC this cycle
//  pc_src      out  2      0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
//  alu_src_a   out  1      0 = rs1, 1 = PC (AUIPC)
//  alu_src_b   out  1      0 = rs2, 1 = imm
//  reg_write   out  1      regfile write enable
//  wb_sel      out  2      0 = ALU result, 1 = load data, 2 = PC+4
//  retire      out  1      one-cycle pulse per completed instruction
//  inst_cnt    out  CNT_W  retired-instruction count; wraps to 0 after all-ones
//  state       out  3      IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6
//  halted      out  1      1 in HALT
//  err         out  1      1 in ERR
// BEHAVIOUR
//  Reset (async): state=IF, inst_cnt=0, timeout counter=0, halted=err=0.
//   While RSTn=0, outputs decode as IF with no ack: i_req=1, all others 0.
//   A mid-instruction reset aborts it. No PC/reg/mem write occurs and no retire is counted.
//  Outputs are pure decodes of state and opcode. Exception: ir_write, pc_write, reg_write and retire
//   are qualified by ack or branch terms as noted below.
//  IF:   i_req=1. On i_ack, assert ir_write and go to ID; otherwise stay.
//  ID:   halt_req=1 -> HALT. Illegal opcode -> ERR.
//   Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
//   Otherwise -> EX.
//  EX:   alu_src_a=1 for AUIPC only. alu_src_b=1 for all opcodes except R-type and branch.
//   Branch: pc_write=1, pc_src = br_taken ? 1 : 0, retire=1 -> IF.
//   Load/store -> MEM. All other opcodes -> WB.
//  MEM:  d_req=1, d_we=1 for store. Hold until d_ack.
//   On d_ack: load -> WB; store -> pc_write=1, pc_src=0, retire=1 -> IF.
//  WB:   reg_write=1 and pc_write=1, retire=1 -> IF.
//   wb_sel: 1 for load, 2 for JAL/JALR, otherwise 0.
//   pc_src: 1 for JAL, 2 for JALR, otherwise 0.
//  HALT, ERR: sticky until reset. All enables and requests are 0.
//  Cycles per instruction with zero-wait ack (ack in the first req cycle):
//   branch 3, store 4, ALU/U/jump 4, load 5.
//  Acks that arrive while the matching req=0 are ignored.
//  i_ack and d_ack asserted in the same cycle: only the ack matching the current state is honoured.
//  Timeout: a counter clears on entry to IF/MEM and increments each cycle req is high without ack.
//   When TIMEOUT!=0 and the counter reaches TIMEOUT with still no ack -> ERR on the next edge.
//   Ack on the cycle count==TIMEOUT wins.
//  inst_cnt increments on each retire and wraps modulo 2^CNT_W.
//  rd=x0 suppression belongs to the register file, not this block.
// TESTING
//  1. RSTn low 3 cycles, then ADDI with i_ack immediate -> states 0,1,2,4,0.
//     reg_write, pc_write and retire pulse in WB; inst_cnt=1.
//  2. LW with d_ack delayed 3 cycles -> d_req high 4 cycles with d_we=0.
//     Then WB with wb_sel=1; total 8 cycles.
//  3. BEQ with br_taken=1, then BNE with br_taken=0 -> pc_src=1, then 0.
//     Each takes 3 cycles and reg_write stays 0.
//  4. JALR -> in WB: wb_sel=2, pc_src=2, reg_write=1.
//     Illegal opcode 7'b1111111 -> ERR after ID; err=1 and sticky.
//  5. TIMEOUT=4, i_ack never asserted -> ERR after 5 IF cycles.
//     Repeat with i_ack in the 5th cycle -> ID, no err.
//  6. RSTn asserted in MEM of SW -> d_req drops immediately, no retire, inst_cnt unchanged.
//     halt_req in ID -> HALT, halted=1.
//     CNT_W=4 with 16 retires -> inst_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath: IF -> ID -> EX -> [MEM] -> [WB].
// Outputs decode the current state and opcode, qualified by the ack and branch terms.
module multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [6:0]       opcode,
   input  logic             br_taken,
   input  logic             halt_req,
   output logic             i_req,
   input  logic             i_ack,
   output logic             d_req,
   output logic             d_we,
   input  logic             d_ack,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             retire,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [2:0]       state,
   output logic             halted,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam int           TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE = TW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              i_ack_s, d_ack_s, tmo_hit_s;
   logic              is_load_s, is_store_s, is_br_s, is_jal_s, is_jalr_s;

   // Acks are ignored while reset is held so IF shows no ir_write.
   assign i_ack_s    = i_ack & RSTn;
   assign d_ack_s    = d_ack & RSTn;
   assign tmo_hit_s  = (TIMEOUT != 0) && (tmo_q == TMO_LIM);
   assign is_load_s  = (opcode == OP_LOAD);
   assign is_store_s = (opcode == OP_STORE);
   assign is_br_s    = (opcode == OP_BR);
   assign is_jal_s   = (opcode == OP_JAL);
   assign is_jalr_s  = (opcode == OP_JALR);

   // Next-state, request-timeout counter and retire counter.
   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      case (state_q)
         S_IF: begin
            if (i_ack_s)        state_d = S_ID;
            else if (tmo_hit_s) state_d = S_ERR;
            else                state_d = S_IF;
         end
         S_ID: begin
            if (halt_req)              state_d = S_HALT;
            else if (!is_legal(opcode)) state_d = S_ERR;
            else                        state_d = S_EX;
         end
         S_EX: begin
            if (is_br_s)                      state_d = S_IF;
            else if (is_load_s || is_store_s) state_d = S_MEM;
            else                              state_d = S_WB;
         end
         S_MEM: begin
            if (d_ack_s)        state_d = is_load_s ? S_WB : S_IF;
            else if (tmo_hit_s) state_d = S_ERR;
            else                state_d = S_MEM;
         end
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
      // Counter is zero in every other state, so it starts clear on entry to IF/MEM.
      if ((TIMEOUT != 0) &&
          (((state_q == S_IF) && !i_ack_s) || ((state_q == S_MEM) && !d_ack_s))) begin
         tmo_d = tmo_q + TMO_ONE;
      end else begin
         tmo_d = '0;
      end
      if (retire) cnt_d = cnt_q + CNT_ONE;
      else        cnt_d = cnt_q;
   end

   // State, timeout and instruction-count registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IF;
         tmo_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output decode.
   always_comb begin
      i_req     = 1'b0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      case (state_q)
         S_IF: begin
            i_req    = 1'b1;
            ir_write = i_ack_s;
         end
         S_EX: begin
            alu_src_a = (opcode == OP_AUIPC);
            alu_src_b = !((opcode == OP_R) || is_br_s);
            if (is_br_s) begin
               pc_write = 1'b1;
               pc_src   = br_taken ? 2'd1 : 2'd0;
               retire   = 1'b1;
            end else begin
               pc_write = 1'b0;
            end
         end
         S_MEM: begin
            d_req = 1'b1;
            d_we  = is_store_s;
            if (d_ack_s && is_store_s) begin
               pc_write = 1'b1;
               retire   = 1'b1;
            end else begin
               pc_write = 1'b0;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            wb_sel    = is_load_s ? 2'd1 : ((is_jal_s || is_jalr_s) ? 2'd2 : 2'd0);
            pc_src    = is_jal_s ? 2'd1 : (is_jalr_s ? 2'd2 : 2'd0);
         end
         default: begin
            i_req = 1'b0;
         end
      endcase
   end

   assign state    = state_q;
   assign halted   = (state_q == S_HALT);
   assign err      = (state_q == S_ERR);
   assign inst_cnt = cnt_q;

endmodule
